// File: rtl/nano_mem_pkg.sv
// Shared types and default widths for the NanoCPU memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nano_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN, DUMP} mem_state_t;

  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/nano_ram_1w1r.sv
// Single-write-port RAM with a combinational read port.
// Latency: write lands on the clock edge; read data is valid in the same cycle.
// Backpressure: none; every enabled write is taken.
module nano_ram_1w1r #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              ck,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  // Storage is deliberately not reset; the owner zeroes it by writing.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port.
  always_ff @(posedge ck) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/nano_mem_responder.sv
// NanoCPU memory: clears RAM, boots a program stream, serves the CPU, dumps RAM on request.
// Latency: CPU read combinational, CPU write on the edge; load/dump take one word per accepted cycle.
// Backpressure: load_valid low stalls loading; dump_ready low freezes the dump word.
module nano_mem_responder
  import nano_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int CLEAR_ON_RESET = 1,
  parameter int DUMP_LAST      = 255
) (
  input  logic              ck,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              ce,
  input  logic              we,
  input  logic [DATA_W-1:0] dataW,
  output logic [DATA_W-1:0] dataR,
  output logic              cpu_rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;
  localparam logic [ADDR_W-1:0] DUMP_END = DUMP_LAST[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam mem_state_t        RST_ST   = (CLEAR_ON_RESET != 0) ? CLEAR : LOAD;

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_dat;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_dat;

  // Next state, pointer, and RAM port muxing (clear / load / CPU write; CPU / dump read).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    wr_dat  = '0;
    rd_addr = address;
    case (state_q)
      CLEAR: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q == PTR_MAX) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (load_valid) begin
          wr_en  = 1'b1;
          wr_dat = load_data;
          ptr_d  = ptr_q + PTR_ONE;
          if (load_last || (ptr_q == PTR_MAX)) begin
            state_d = RUN;
            ptr_d   = '0;
          end
        end
      end
      RUN: begin
        // The CPU write in the dump_req cycle still lands.
        wr_en   = ce && we;
        wr_addr = address;
        wr_dat  = dataW;
        if (dump_req) begin
          state_d = DUMP;
        end
      end
      DUMP: begin
        rd_addr = ptr_q;
        if (dump_ready) begin
          ptr_d = ptr_q + PTR_ONE;
          if (ptr_q == DUMP_END) begin
            state_d = RUN;
            ptr_d   = '0;
          end
        end
      end
      default: begin
        state_d = RST_ST;
      end
    endcase
    // Reset aborts whatever was in flight, including a pending RAM write.
    if (rst) begin
      wr_en = 1'b0;
    end
    cpu_rst_d = (state_d != RUN);
  end

  // State, pointer and registered CPU reset.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= RST_ST;
      ptr_q     <= '0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  nano_ram_1w1r #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .ck      (ck),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  assign dataR      = (state_q == RUN) ? rd_dat : '0;
  assign cpu_rst    = cpu_rst_q;
  assign load_ready = (state_q == LOAD);
  assign dump_valid = (state_q == DUMP);
  assign dump_addr  = dump_valid ? ptr_q : '0;
  assign dump_data  = dump_valid ? rd_dat : '0;
  assign busy       = (state_q != RUN);

endmodule
